// File: rtl/rtx_pkg.sv
// Shared types for the ray-tracer pixel scheduler slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rtx_pkg;

  localparam int H_W = 11;  // column width
  localparam int V_W = 10;  // row width

  typedef logic [2:0][7:0] color_t;

  typedef struct packed {
    logic [H_W-1:0] h;
    logic [V_W-1:0] v;
    color_t         color;
  } pixel_res_t;

endpackage

// File: rtl/pixel_scheduler_if.sv
// Core-side job/result bus plus frame-buffer write port of the pixel scheduler.
// Latency: n/a (wiring only).
// Backpressure: results use valid/ready per core; jobs are issued only to idle cores.
// master = scheduler side, slave = cores / frame buffer / control side.
interface pixel_scheduler_if #(
  parameter int NUM_CORES = 4
);
  import rtx_pkg::*;

  logic                      run;
  logic [NUM_CORES-1:0]      core_idle;
  logic [NUM_CORES-1:0]      job_valid;
  logic [H_W-1:0]            job_h;
  logic [V_W-1:0]            job_v;
  logic [NUM_CORES-1:0]      res_valid;
  logic [NUM_CORES*H_W-1:0]  res_h;
  logic [NUM_CORES*V_W-1:0]  res_v;
  logic [NUM_CORES*24-1:0]   res_color;
  logic [NUM_CORES-1:0]      res_ready;
  logic [H_W-1:0]            pixel_h;
  logic [V_W-1:0]            pixel_v;
  logic [23:0]               new_color;
  logic                      new_color_valid;
  logic [15:0]               frame_count;
  logic                      frame_done;
  logic                      busy;

  modport master (
    input  run, core_idle, res_valid, res_h, res_v, res_color,
    output job_valid, job_h, job_v, res_ready,
           pixel_h, pixel_v, new_color, new_color_valid,
           frame_count, frame_done, busy
  );

  modport slave (
    output run, core_idle, res_valid, res_h, res_v, res_color,
    input  job_valid, job_h, job_v, res_ready,
           pixel_h, pixel_v, new_color, new_color_valid,
           frame_count, frame_done, busy
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the pointer.
// Latency: grant is combinational from req; pointer updates on the clock edge.
// Backpressure: pointer only moves past the grantee when advance is high.
// Ports: clk_rtx, rst (sync, active-high), req[N], advance -> grant[N].
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk_rtx,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] nxt_ptr;
  logic          found;
  int            idx;

  always_comb begin
    grant   = '0;
    nxt_ptr = ptr;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < N; k++) begin
      // Walk the ring starting at the highest-priority slot.
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!found && req[PW'(idx)]) begin
        found            = 1'b1;
        grant[PW'(idx)]  = 1'b1;
        nxt_ptr          = (idx == N - 1) ? '0 : PW'(idx + 1);
      end
    end
  end

  always_ff @(posedge clk_rtx) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance && found) begin
      ptr <= nxt_ptr;
    end
  end

endmodule

// File: rtl/pixel_scheduler.sv
// Dispatches raster-order pixel jobs to NUM_CORES cores and writes their results to the frame buffer.
// Latency: job 1 cycle after core_idle; frame-buffer write 1 cycle after the result handshake.
// Backpressure: results are granted only when the write gap counter is 0 (>= WRITE_GAP cycles per write).
// Ports: clk_rtx, rst (sync, active-high), bus (master modport: run/core_idle/job_*, res_*, pixel_*/new_color*, frame_*, busy).
module pixel_scheduler
  import rtx_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int SIZE_H    = 320,
  parameter int SIZE_V    = 180,
  parameter int WRITE_GAP = 3
) (
  input  logic               clk_rtx,
  input  logic               rst,
  pixel_scheduler_if.master  bus
);

  localparam int TOTAL = SIZE_H * SIZE_V;
  localparam int WCW   = $clog2(TOTAL + 1);
  localparam int GW    = $clog2(WRITE_GAP);

  localparam logic [H_W-1:0] LAST_H   = H_W'(SIZE_H - 1);
  localparam logic [V_W-1:0] LAST_V   = V_W'(SIZE_V - 1);
  localparam logic [WCW-1:0] LAST_W   = WCW'(TOTAL - 1);
  localparam logic [GW-1:0]  GAP_LOAD = GW'(WRITE_GAP - 1);

  // ---------------- dispatch ----------------
  logic [NUM_CORES-1:0] disp_req;
  logic [NUM_CORES-1:0] disp_gnt;
  logic [H_W-1:0]       ptr_h;
  logic [V_W-1:0]       ptr_v;

  assign disp_req = bus.run ? bus.core_idle : '0;

  rr_arbiter #(.N(NUM_CORES)) u_disp_arb (
    .clk_rtx (clk_rtx),
    .rst     (rst),
    .req     (disp_req),
    .advance (|disp_req),
    .grant   (disp_gnt)
  );

  always_ff @(posedge clk_rtx) begin
    if (rst) begin
      bus.job_valid <= '0;
      bus.job_h     <= '0;
      bus.job_v     <= '0;
      ptr_h         <= '0;
      ptr_v         <= '0;
    end else begin
      bus.job_valid <= disp_gnt;
      if (|disp_gnt) begin
        bus.job_h <= ptr_h;
        bus.job_v <= ptr_v;
        if (ptr_h == LAST_H) begin
          ptr_h <= '0;
          ptr_v <= (ptr_v == LAST_V) ? '0 : ptr_v + 1'b1;
        end else begin
          ptr_h <= ptr_h + 1'b1;
        end
      end
    end
  end

  // ---------------- collection ----------------
  logic [GW-1:0]        gap_cnt;
  logic [NUM_CORES-1:0] res_req;
  logic [NUM_CORES-1:0] res_gnt;
  logic                 handshake;
  logic [WCW-1:0]       wr_cnt;
  pixel_res_t           sel;

  // While the frame buffer is still averaging the previous write, nobody is granted.
  assign res_req       = (gap_cnt == '0) ? bus.res_valid : '0;
  assign bus.res_ready = res_gnt;
  assign handshake     = |res_gnt;
  assign bus.busy      = (|bus.res_valid) | (gap_cnt != '0);

  rr_arbiter #(.N(NUM_CORES)) u_res_arb (
    .clk_rtx (clk_rtx),
    .rst     (rst),
    .req     (res_req),
    .advance (handshake),
    .grant   (res_gnt)
  );

  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (res_gnt[i]) begin
        sel.h     = bus.res_h[i*H_W +: H_W];
        sel.v     = bus.res_v[i*V_W +: V_W];
        sel.color = bus.res_color[i*24 +: 24];
      end
    end
  end

  always_ff @(posedge clk_rtx) begin
    if (rst) begin
      gap_cnt             <= '0;
      wr_cnt              <= '0;
      bus.pixel_h         <= '0;
      bus.pixel_v         <= '0;
      bus.new_color       <= '0;
      bus.new_color_valid <= 1'b0;
      bus.frame_done      <= 1'b0;
      bus.frame_count     <= '0;
    end else if (handshake) begin
      bus.pixel_h         <= sel.h;
      bus.pixel_v         <= sel.v;
      bus.new_color       <= sel.color;
      bus.new_color_valid <= 1'b1;
      gap_cnt             <= GAP_LOAD;
      // Frame accounting lands in the same cycle as the strobe of the write.
      if (wr_cnt == LAST_W) begin
        wr_cnt          <= '0;
        bus.frame_done  <= 1'b1;
        bus.frame_count <= bus.frame_count + 16'd1;
      end else begin
        wr_cnt         <= wr_cnt + 1'b1;
        bus.frame_done <= 1'b0;
      end
    end else begin
      bus.new_color_valid <= 1'b0;
      bus.frame_done      <= 1'b0;
      if (gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;
    end
  end

endmodule

// File: tb/tb_pixel_scheduler.sv
// Directed bench for pixel_scheduler: dispatch order and wrap, result arbitration and write spacing,
// run pause/resume, reset during a handshake, and frame accounting on a reduced-size instance.
module tb_pixel_scheduler;

  logic clk_rtx;
  logic rst;
  logic rst_s;

  int n_chk;
  int n_bad;

  pixel_scheduler_if #(.NUM_CORES(4)) bus ();
  pixel_scheduler_if #(.NUM_CORES(2)) sbus ();

  pixel_scheduler #(
    .NUM_CORES(4), .SIZE_H(320), .SIZE_V(180), .WRITE_GAP(3)
  ) u_dut (
    .clk_rtx (clk_rtx),
    .rst     (rst),
    .bus     (bus)
  );

  pixel_scheduler #(
    .NUM_CORES(2), .SIZE_H(6), .SIZE_V(3), .WRITE_GAP(3)
  ) u_small (
    .clk_rtx (clk_rtx),
    .rst     (rst_s),
    .bus     (sbus)
  );

  initial clk_rtx = 1'b0;
  always #5 clk_rtx = ~clk_rtx;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] core_col(input int i);
    return 24'h102030 + 24'(i) * 24'h010101;
  endfunction

  initial begin
    int w;
    int last_cyc;
    int fd_cnt;

    n_chk = 0;
    n_bad = 0;

    rst = 1'b1;
    rst_s = 1'b1;
    bus.run = 1'b0;
    bus.core_idle = '0;
    bus.res_valid = '0;
    bus.res_h = '0;
    bus.res_v = '0;
    bus.res_color = '0;
    sbus.run = 1'b0;
    sbus.core_idle = '0;
    sbus.res_valid = '0;
    sbus.res_h = '0;
    sbus.res_v = '0;
    sbus.res_color = '0;
    for (int i = 0; i < 4; i++) begin
      bus.res_h[i*11 +: 11]     = 11'(100 + i);
      bus.res_v[i*10 +: 10]     = 10'(50 + i);
      bus.res_color[i*24 +: 24] = core_col(i);
    end

    repeat (3) @(posedge clk_rtx);
    @(negedge clk_rtx);
    #1;
    chk("rst_job_valid", bus.job_valid, 0);
    chk("rst_job_h", bus.job_h, 0);
    chk("rst_job_v", bus.job_v, 0);
    chk("rst_ncv", bus.new_color_valid, 0);
    chk("rst_pixel_h", bus.pixel_h, 0);
    chk("rst_new_color", bus.new_color, 0);
    chk("rst_frame_count", bus.frame_count, 0);
    chk("rst_frame_done", bus.frame_done, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_res_ready", bus.res_ready, 0);

    // Dispatch: all cores idle, one job per cycle in raster order.
    rst = 1'b0;
    bus.run = 1'b1;
    bus.core_idle = 4'hf;
    for (int n = 0; n <= 57600; n++) begin
      @(negedge clk_rtx);
      if (n < 8 || n == 319 || n == 320 || n == 1616 || n == 1617 || n == 57599 || n == 57600) begin
        chk($sformatf("job_valid_%0d", n), bus.job_valid, 4'b0001 << (n % 4));
        chk($sformatf("job_h_%0d", n), bus.job_h, n % 320);
        chk($sformatf("job_v_%0d", n), bus.job_v, (n / 320) % 180);
      end
      if (n == 1616) begin
        // Pause dispatch at pointer (17,5) and drain results meanwhile.
        bus.run = 1'b0;
        for (int c = 0; c < 20; c++) begin
          @(negedge clk_rtx);
          bus.res_valid = (c < 12) ? 4'hf : 4'h0;
          #1;
          chk("paused_job_valid", bus.job_valid, 0);
          if (c < 12)
            chk($sformatf("res_ready_c%0d", c), bus.res_ready,
                (c % 3 == 0) ? (4'b0001 << ((c / 3) % 4)) : 4'b0000);
          if (c < 14)
            chk($sformatf("ncv_c%0d", c), bus.new_color_valid, (c % 3 == 1) && (c < 12));
          if (c % 3 == 1 && c < 12) begin
            chk($sformatf("pixel_h_c%0d", c), bus.pixel_h, 100 + (c / 3) % 4);
            chk($sformatf("pixel_v_c%0d", c), bus.pixel_v, 50 + (c / 3) % 4);
            chk($sformatf("new_color_c%0d", c), bus.new_color, core_col((c / 3) % 4));
          end
          if (c == 2) begin
            chk("pixel_h_hold", bus.pixel_h, 100);
            chk("busy_in_gap", bus.busy, 1);
          end
        end
        bus.run = 1'b1;
      end
    end

    // Reset lands on the edge that ends a handshake cycle: that write must never appear.
    @(negedge clk_rtx);
    bus.run = 1'b0;
    bus.res_valid = 4'b0100;
    rst = 1'b1;
    #1;
    chk("hs_res_ready", bus.res_ready, 4'b0100);
    @(negedge clk_rtx);
    chk("rst_mid_ncv", bus.new_color_valid, 0);
    chk("rst_mid_job_valid", bus.job_valid, 0);
    chk("rst_mid_job_h", bus.job_h, 0);
    chk("rst_mid_pixel_h", bus.pixel_h, 0);
    chk("rst_mid_pixel_v", bus.pixel_v, 0);
    chk("rst_mid_new_color", bus.new_color, 0);
    bus.res_valid = 4'b0000;
    #1;
    chk("rst_mid_busy", bus.busy, 0);
    chk("rst_mid_res_ready", bus.res_ready, 0);
    rst = 1'b0;
    bus.run = 1'b1;
    @(negedge clk_rtx);
    chk("post_rst_job_valid", bus.job_valid, 4'b0001);
    chk("post_rst_job_h", bus.job_h, 0);
    chk("post_rst_job_v", bus.job_v, 0);
    bus.run = 1'b0;
    bus.core_idle = '0;

    // Frame accounting on a 6x3 frame: 18 writes per frame, two frames.
    sbus.res_valid = 2'b01;
    sbus.res_h[10:0] = 11'd5;
    sbus.res_v[9:0] = 10'd2;
    sbus.res_color[23:0] = 24'hABCDEF;
    rst_s = 1'b0;
    w = 0;
    last_cyc = 0;
    fd_cnt = 0;
    for (int cyc = 0; cyc < 300 && w < 36; cyc++) begin
      @(negedge clk_rtx);
      if (sbus.frame_done) fd_cnt++;
      if (sbus.new_color_valid) begin
        w++;
        if (w == 2 || w == 19) chk($sformatf("write_spacing_%0d", w), cyc - last_cyc, 3);
        last_cyc = cyc;
        if (w == 1) chk("small_new_color", sbus.new_color, 24'hABCDEF);
        if (w == 17) begin
          chk("fd_w17", sbus.frame_done, 0);
          chk("fc_w17", sbus.frame_count, 0);
        end
        if (w == 18) begin
          chk("fd_w18", sbus.frame_done, 1);
          chk("fc_w18", sbus.frame_count, 1);
        end
        if (w == 19) begin
          chk("fd_w19", sbus.frame_done, 0);
          chk("fc_w19", sbus.frame_count, 1);
        end
        if (w == 36) begin
          chk("fd_w36", sbus.frame_done, 1);
          chk("fc_w36", sbus.frame_count, 2);
        end
      end else begin
        if (sbus.frame_done) chk("fd_without_write", sbus.frame_done, 0);
      end
    end
    chk("small_write_total", w, 36);
    chk("small_fd_pulses", fd_cnt, 2);
    chk("main_frame_count", bus.frame_count, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
